// File: rtl/prog_tick_gen_pkg.sv
// ============================================================================
// Package  : prog_tick_gen_pkg
// Brief    : Shared defaults and per-channel control-state type for the
//            programmable tick generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package prog_tick_gen_pkg;

  // Default channel count and divisor/counter width
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 32;

  // Divisor that turns a 50 MHz reference into a 1 Hz tick
  localparam int unsigned DIV_50M_1HZ = 32'd50_000_000;

  // Single-bit control state carried by every channel
  typedef struct packed {
    logic run;      // channel counted on the previous edge
    logic pend;     // shadow divisor waiting to be applied
    logic clk_out;  // registered divided clock
    logic tick;     // registered period-complete pulse
  } ch_state_t;

endpackage

`default_nettype wire

// File: rtl/tick_gen_ch.sv
// ============================================================================
// Module   : tick_gen_ch
// Brief    : One divider channel: active divisor D, shadow divisor S,
//            counter and registered clk_out / tick / pend outputs.
//            Macro PROG_TICK_GEN_SYNC_EN adds the global sync input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen_ch
  import prog_tick_gen_pkg::*;
#(
  parameter int               CNT_W   = DEF_CNT_W,
  parameter logic [CNT_W-1:0] RST_DIV = CNT_W'(DIV_50M_1HZ)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef PROG_TICK_GEN_SYNC_EN
  input  logic             sync,
`endif
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_data,
  output logic             clk_out,
  output logic             tick,
  output logic             pend
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] d_q, d_d;
  logic [CNT_W-1:0] s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_w;
  ch_state_t        st_q, st_d;
  logic             sync_w;
  logic             d_nz_w;
  logic             wrap_w;
  logic             apply_w;

`ifdef PROG_TICK_GEN_SYNC_EN
  assign sync_w = sync;
`else
  assign sync_w = 1'b0;
`endif

  // Next-state: counting, wrap detection, shadow hand-over and output decode
  always_comb begin
    d_nz_w  = (d_q != '0);
    // D-1 is only meaningful when D is non-zero, so the wrap test is gated
    wrap_w  = st_q.run && en && d_nz_w && (cnt_q == d_q - CNT_ONE);
    // The shadow is handed over only where it cannot cut a period short
    apply_w = st_q.pend && (sync_w || wrap_w || !en || !d_nz_w);

    d_d       = apply_w ? s_q : d_q;
    s_d       = wr ? wr_data : s_q;
    st_d      = '0;
    // A write on the hand-over edge stays queued for the next wrap
    st_d.pend = wr || (st_q.pend && !apply_w);
    st_d.run  = en && (d_d != '0);

    if (!st_d.run) begin
      cnt_d = '0;
    end else if (sync_w || apply_w || wrap_w || !st_q.run) begin
      // Phase restart, new divisor, wrap, or first edge after start-up
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    half_w       = (d_d >> 1) + CNT_W'(d_d[0]);
    st_d.clk_out = st_d.run && (cnt_d < half_w);
    // No pulse when the channel stops on this edge or the phase is restarted
    st_d.tick    = wrap_w && st_d.run && !sync_w;
  end

  // Channel registers, cleared asynchronously to the reset divisor
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q   <= RST_DIV;
      s_q   <= RST_DIV;
      cnt_q <= '0;
      st_q  <= '0;
    end else begin
      d_q   <= d_d;
      s_q   <= s_d;
      cnt_q <= cnt_d;
      st_q  <= st_d;
    end
  end

  assign clk_out = st_q.clk_out;
  assign tick    = st_q.tick;
  assign pend    = st_q.pend;

endmodule

`default_nettype wire

// File: rtl/prog_tick_gen.sv
// ============================================================================
// Module   : prog_tick_gen
// Brief    : NUM_CH independent programmable clock dividers with glitch-free
//            divisor update. Defining PROG_TICK_GEN_SYNC_EN adds the sync
//            input, which restarts the phase of every enabled channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_tick_gen
  import prog_tick_gen_pkg::*;
#(
  parameter int          NUM_CH  = DEF_NUM_CH,
  parameter int          CNT_W   = DEF_CNT_W,
  parameter int unsigned RST_DIV = DIV_50M_1HZ,
  localparam int         SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef PROG_TICK_GEN_SYNC_EN
  input  logic              sync,
`endif
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [CNT_W-1:0]  wr_data,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend
);

  // One channel per index; a select beyond NUM_CH-1 matches no channel
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_hit;
    assign wr_hit = wr_en && (wr_sel == SEL_W'(i));

    tick_gen_ch #(
      .CNT_W   (CNT_W),
      .RST_DIV (CNT_W'(RST_DIV))
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
`ifdef PROG_TICK_GEN_SYNC_EN
      .sync    (sync),
`endif
      .en      (ch_en[i]),
      .wr      (wr_hit),
      .wr_data (wr_data),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .pend    (pend[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_prog_tick_gen.sv
// ============================================================================
// Module   : tb_prog_tick_gen
// Brief    : Directed self-checking bench for prog_tick_gen (3 channels,
//            8-bit counters, reset divisor 4). The sync scenario is built
//            only when PROG_TICK_GEN_SYNC_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_tick_gen;

  localparam int NUM_CH  = 3;
  localparam int CNT_W   = 8;
  localparam int RST_DIV = 4;
  localparam int SEL_W   = 2;

  logic              clk     = 1'b0;
  logic              rst_n   = 1'b0;
  logic              wr_en   = 1'b0;
  logic [SEL_W-1:0]  wr_sel  = '0;
  logic [CNT_W-1:0]  wr_data = '0;
  logic [NUM_CH-1:0] ch_en   = '0;
`ifdef PROG_TICK_GEN_SYNC_EN
  logic              sync    = 1'b0;
`endif
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] pend;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prog_tick_gen #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .RST_DIV (RST_DIV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef PROG_TICK_GEN_SYNC_EN
    .sync    (sync),
`endif
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_data (wr_data),
    .ch_en   (ch_en),
    .clk_out (clk_out),
    .tick    (tick),
    .pend    (pend)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ch_en = '0; wr_en = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ch_en = '1; wr_en = 1'b1; wr_sel = 2'd0; wr_data = 8'd9;
    step(); step();
    n_vec++; if (clk_out !== 3'b000) begin n_err++; $display("FAIL reset_clk got %b want 000", clk_out); end
    n_vec++; if (tick !== 3'b000) begin n_err++; $display("FAIL reset_tick got %b want 000", tick); end
    n_vec++; if (pend !== 3'b000) begin n_err++; $display("FAIL reset_pend got %b want 000", pend); end
    wr_en = 1'b0; ch_en = '0;
  endtask

  task automatic test_basic();
    bit [0:7] ce, te;
    ce = 8'b1100_1100; te = 8'b0000_1000;
    do_reset(); ch_en = 3'b001;
    for (int k = 0; k < 8; k++) begin
      step();
      n_vec++; if (clk_out !== {2'b00, ce[k]}) begin n_err++; $display("FAIL basic_clk e%0d got %b want %b", k+1, clk_out, {2'b00, ce[k]}); end
      n_vec++; if (tick !== {2'b00, te[k]}) begin n_err++; $display("FAIL basic_tick e%0d got %b want %b", k+1, tick, {2'b00, te[k]}); end
    end
  endtask

  task automatic test_d5_d1();
    bit [0:9] ce0, te0, te1;
    ce0 = 10'b1110011100; te0 = 10'b0000010000; te1 = 10'b0111111111;
    do_reset();
    wr_en = 1'b1; wr_sel = 2'd0; wr_data = 8'd5; step();
    n_vec++; if (pend !== 3'b001) begin n_err++; $display("FAIL d5_pend_a got %b want 001", pend); end
    wr_sel = 2'd1; wr_data = 8'd1; step();
    n_vec++; if (pend !== 3'b010) begin n_err++; $display("FAIL d5_pend_b got %b want 010", pend); end
    wr_en = 1'b0; step();
    n_vec++; if (pend !== 3'b000) begin n_err++; $display("FAIL d5_pend_c got %b want 000", pend); end
    ch_en = 3'b011;
    for (int k = 0; k < 10; k++) begin
      step();
      n_vec++; if (clk_out !== {1'b0, 1'b1, ce0[k]}) begin n_err++; $display("FAIL d5d1_clk e%0d got %b want %b", k+1, clk_out, {1'b0, 1'b1, ce0[k]}); end
      n_vec++; if (tick !== {1'b0, te1[k], te0[k]}) begin n_err++; $display("FAIL d5d1_tick e%0d got %b want %b", k+1, tick, {1'b0, te1[k], te0[k]}); end
    end
  endtask

  task automatic test_retime();
    bit [0:31] ce, te, pe;
    ce = 32'b1100_1111_0000_1111_0000_1111_0000_1101;
    te = 32'b0000_1000_0000_1000_0000_1000_0000_1001;
    pe = 32'b0011_0000_0000_0000_0000_1111_1111_0000;
    do_reset(); ch_en = 3'b010; wr_sel = 2'd1;
    for (int k = 0; k < 32; k++) begin
      wr_en   = (k == 2) || (k == 20);
      wr_data = (k == 2) ? 8'd8 : 8'd3;
      step();
      n_vec++; if (clk_out !== {1'b0, ce[k], 1'b0}) begin n_err++; $display("FAIL retime_clk e%0d got %b want %b", k+1, clk_out, {1'b0, ce[k], 1'b0}); end
      n_vec++; if (tick !== {1'b0, te[k], 1'b0}) begin n_err++; $display("FAIL retime_tick e%0d got %b want %b", k+1, tick, {1'b0, te[k], 1'b0}); end
      n_vec++; if (pend !== {1'b0, pe[k], 1'b0}) begin n_err++; $display("FAIL retime_pend e%0d got %b want %b", k+1, pend, {1'b0, pe[k], 1'b0}); end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_halt();
    bit [0:11] ce, te, pe;
    ce = 12'b1100_0001_1011; te = 12'b0000_0000_0010; pe = 12'b0011_0010_0000;
    do_reset(); ch_en = 3'b001; wr_sel = 2'd0;
    for (int k = 0; k < 12; k++) begin
      wr_en   = (k == 2) || (k == 6);
      wr_data = (k == 2) ? 8'd0 : 8'd3;
      step();
      n_vec++; if (clk_out !== {2'b00, ce[k]}) begin n_err++; $display("FAIL halt_clk e%0d got %b want %b", k+1, clk_out, {2'b00, ce[k]}); end
      n_vec++; if (tick !== {2'b00, te[k]}) begin n_err++; $display("FAIL halt_tick e%0d got %b want %b", k+1, tick, {2'b00, te[k]}); end
      n_vec++; if (pend !== {2'b00, pe[k]}) begin n_err++; $display("FAIL halt_pend e%0d got %b want %b", k+1, pend, {2'b00, pe[k]}); end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_enable();
    bit [0:9] ce, te;
    ce = 10'b1100011001; te = 10'b0000000001;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      ch_en = (k == 3 || k == 4) ? 3'b000 : 3'b100;
      step();
      n_vec++; if (clk_out !== {ce[k], 2'b00}) begin n_err++; $display("FAIL enable_clk e%0d got %b want %b", k+1, clk_out, {ce[k], 2'b00}); end
      n_vec++; if (tick !== {te[k], 2'b00}) begin n_err++; $display("FAIL enable_tick e%0d got %b want %b", k+1, tick, {te[k], 2'b00}); end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ce [4];
    logic [2:0] te [4];
    ce = '{3'b111, 3'b100, 3'b011, 3'b000};
    te = '{3'b000, 3'b000, 3'b011, 3'b000};
    do_reset();
    wr_en = 1'b1; wr_sel = 2'd3; wr_data = 8'd7; step();
    n_vec++; if (pend !== 3'b000) begin n_err++; $display("FAIL b2b_oor_pend got %b want 000", pend); end
    wr_sel = 2'd0; wr_data = 8'd2; step();
    n_vec++; if (pend !== 3'b001) begin n_err++; $display("FAIL b2b_pend_a got %b want 001", pend); end
    wr_sel = 2'd1; wr_data = 8'd2; step();
    n_vec++; if (pend !== 3'b010) begin n_err++; $display("FAIL b2b_pend_b got %b want 010", pend); end
    wr_en = 1'b0; step();
    n_vec++; if (pend !== 3'b000) begin n_err++; $display("FAIL b2b_pend_c got %b want 000", pend); end
    ch_en = 3'b111;
    for (int k = 0; k < 4; k++) begin
      step();
      n_vec++; if (clk_out !== ce[k]) begin n_err++; $display("FAIL b2b_clk e%0d got %b want %b", k+1, clk_out, ce[k]); end
      n_vec++; if (tick !== te[k]) begin n_err++; $display("FAIL b2b_tick e%0d got %b want %b", k+1, tick, te[k]); end
    end
  endtask

  task automatic test_async_reset();
    bit [0:7] ce, te;
    ce = 8'b1100_1100; te = 8'b0000_1000;
    do_reset(); ch_en = 3'b001;
    step();
    wr_en = 1'b1; wr_sel = 2'd0; wr_data = 8'd9; step(); wr_en = 1'b0;
    n_vec++; if (clk_out !== 3'b001) begin n_err++; $display("FAIL arst_pre_clk got %b want 001", clk_out); end
    n_vec++; if (pend !== 3'b001) begin n_err++; $display("FAIL arst_pre_pend got %b want 001", pend); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (clk_out !== 3'b000) begin n_err++; $display("FAIL arst_clk got %b want 000", clk_out); end
    n_vec++; if (tick !== 3'b000) begin n_err++; $display("FAIL arst_tick got %b want 000", tick); end
    n_vec++; if (pend !== 3'b000) begin n_err++; $display("FAIL arst_pend got %b want 000", pend); end
    step(); rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      n_vec++; if (clk_out !== {2'b00, ce[k]}) begin n_err++; $display("FAIL arst_post_clk e%0d got %b want %b", k+1, clk_out, {2'b00, ce[k]}); end
      n_vec++; if (tick !== {2'b00, te[k]}) begin n_err++; $display("FAIL arst_post_tick e%0d got %b want %b", k+1, tick, {2'b00, te[k]}); end
      n_vec++; if (pend !== 3'b000) begin n_err++; $display("FAIL arst_post_pend e%0d got %b want 000", k+1, pend); end
    end
  endtask

`ifdef PROG_TICK_GEN_SYNC_EN
  task automatic test_sync();
    bit [0:5] c0, c1, t0, t1;
    c0 = 6'b101101; t0 = 6'b001001; c1 = 6'b110001; t1 = 6'b000001;
    do_reset();
    wr_en = 1'b1; wr_sel = 2'd0; wr_data = 8'd3; step();
    wr_sel = 2'd1; wr_data = 8'd6; step();
    wr_en = 1'b0; step();
    ch_en = 3'b011;
    wr_en = 1'b1; wr_sel = 2'd3; wr_data = 8'd1;
    step(); step(); step();
    wr_en = 1'b0;
    n_vec++; if (pend !== 3'b000) begin n_err++; $display("FAIL sync_oor_pend got %b want 000", pend); end
    n_vec++; if (clk_out !== 3'b010) begin n_err++; $display("FAIL sync_pre_clk got %b want 010", clk_out); end
    sync = 1'b1; step(); sync = 1'b0;
    n_vec++; if (clk_out !== 3'b011) begin n_err++; $display("FAIL sync_edge_clk got %b want 011", clk_out); end
    n_vec++; if (tick !== 3'b000) begin n_err++; $display("FAIL sync_edge_tick got %b want 000", tick); end
    for (int k = 0; k < 6; k++) begin
      step();
      n_vec++; if (clk_out !== {1'b0, c1[k], c0[k]}) begin n_err++; $display("FAIL sync_clk e%0d got %b want %b", k+1, clk_out, {1'b0, c1[k], c0[k]}); end
      n_vec++; if (tick !== {1'b0, t1[k], t0[k]}) begin n_err++; $display("FAIL sync_tick e%0d got %b want %b", k+1, tick, {1'b0, t1[k], t0[k]}); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_d5_d1();
    test_retime();
    test_halt();
    test_enable();
    test_back_to_back();
    test_async_reset();
`ifdef PROG_TICK_GEN_SYNC_EN
    test_sync();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prog_tick_gen.md
PROG_TICK_GEN -- requirements
Module: prog_tick_gen

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 32, divisor/counter width in bits.
REQ-003 Parameter RST_DIV, default 50000000, divisor loaded into every channel at reset (50 MHz -> 1 Hz).
REQ-004 clk  in  1  single clock for all logic; rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 wr_en  in  1  divisor write strobe, one write per cycle.
REQ-007 wr_sel  in  max(1,$clog2(NUM_CH))  target channel of the write.
REQ-008 wr_data  in  CNT_W  new divisor value D.
REQ-009 ch_en  in  NUM_CH  per-channel run enable.
REQ-010 sync  in  1  global phase restart; present only with PROG_TICK_GEN_SYNC_EN.
REQ-011 clk_out  out  NUM_CH  registered divided clock per channel.
REQ-012 tick  out  NUM_CH  registered one-cycle pulse per completed period.
REQ-013 pend  out  NUM_CH  high while a written divisor awaits application.

Function
REQ-014 Each channel SHALL hold an active divisor D, a shadow divisor S and a counter cnt (CNT_W bits).
REQ-015 Enabled channel with D>=1 SHALL count cnt 0..D-1 and wrap to 0; period exactly D clk cycles.
REQ-016 clk_out[i] SHALL be registered (next cnt < ceil(D/2)); high ceil(D/2) cycles, low floor(D/2) cycles per period.
REQ-017 tick[i] SHALL be high for exactly the one cycle following each edge at which cnt wraps D-1 -> 0.
REQ-018 D=1 SHALL give tick high every cycle and clk_out constant 1.
REQ-019 D=0 SHALL halt the channel: cnt=0, clk_out=0, tick=0.
REQ-020 wr_en with wr_sel<NUM_CH SHALL write S[wr_sel]=wr_data and set pend[wr_sel] on the next edge; wr_sel>=NUM_CH SHALL be ignored.
REQ-021 Pending S SHALL be copied to D, cnt cleared, pend cleared at the channel's next wrap edge, or at the next edge if the channel is disabled or D=0 (glitch-free change).
REQ-022 Write on the same edge as a wrap: previous S SHALL be applied; new value SHALL remain in S with pend=1 until the following wrap.
REQ-023 ch_en[i]=0 SHALL clear cnt, drive clk_out[i]=0 and tick[i]=0 from the next edge; re-enable SHALL restart from cnt=0 with clk_out high on the first enabled edge.
REQ-024 Counter arithmetic SHALL be unsigned CNT_W; comparison against D-1 only evaluated for D>=1 (no underflow).
REQ-025 Channels SHALL be fully independent except for sync.

Reset
REQ-026 rst_n low SHALL asynchronously set D=S=RST_DIV, cnt=0, clk_out=0, tick=0, pend=0 for all channels.
REQ-027 First edge after rst_n deasserts SHALL be a normal counting edge; reset mid-period SHALL discard any pending write.

Configuration
REQ-028 With PROG_TICK_GEN_SYNC_EN defined, sync high SHALL on that edge clear cnt of every enabled channel, apply all pending S, clear pend, force tick=0, and set clk_out per cnt=0; sync SHALL override a simultaneous wrap.
REQ-029 Without PROG_TICK_GEN_SYNC_EN, the sync port and logic SHALL be absent; behaviour otherwise identical.

Structure
REQ-030 Package prog_tick_gen_pkg SHALL hold default constants (DEF_NUM_CH, DEF_CNT_W, DIV_50M_1HZ) and the per-channel state struct.
REQ-031 One sub-module, tick_gen_ch (single channel: D, S, cnt, outputs), SHALL be instantiated NUM_CH times by generate.

Verification
REQ-032 RST_DIV=4, ch_en=1 after reset -> clk_out 1,1,0,0 repeating; tick every 4th cycle, first tick 4 cycles after enable.
REQ-033 D=5 -> clk_out high 3 low 2; tick period 5; D=1 -> tick constant 1, clk_out constant 1.
REQ-034 Write 8 to ch1 at cnt=1 of D=4 -> pend[1]=1 until wrap, then period 8 with no short/long pulse; write coincident with wrap -> applied one period later.
REQ-035 Write 0 -> channel halts next edge, outputs 0; write 3 -> restarts immediately, pend clears.
REQ-036 rst_n low mid-period with pending write -> all outputs 0 asynchronously, D=RST_DIV, pend=0.
REQ-037 (SYNC_EN) ch0 D=3, ch1 D=6 free-running; pulse sync -> both cnt=0 next edge, ticks thereafter coincide every 6 cycles; wr_sel=NUM_CH write ignored.
